// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the imem read port and feeds IF/ID.
// Optional PC_MISALIGN_CHECK_EN traps misaligned redirects to TRAP_VECTOR.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_MISALIGN_CHECK_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_SEL,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] FETCH_INSTRUCTION,
    output logic [31:0] FETCH_PC,
    output logic        BUSYWAIT,
    output logic        MISALIGN_FAULT
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_DISCARD,
        S_HELD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_tgt;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + 32'd4;

`ifdef PC_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_fault;

    assign w_misalign = |BRANCH_TARGET[1:0];
    assign w_tgt      = w_misalign ? TRAP_VECTOR : BRANCH_TARGET;

    // Any accepted redirect (every state but boot) can raise the fault.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fault <= 1'b0;
        end else if (PC_SEL && w_misalign && r_state != S_BOOT) begin
            r_fault <= 1'b1;
        end
    end

    assign MISALIGN_FAULT = r_fault;
`else
    assign w_tgt          = BRANCH_TARGET & 32'hFFFF_FFFC;
    assign MISALIGN_FAULT = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_VECTOR;
            r_redirect_tgt <= 32'h0;
            r_hold_instr   <= NOP;
            r_hold_pc      <= 32'h0;
        end else begin
            unique case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (PC_SEL) begin
                        if (IMEM_BUSYWAIT) begin
                            r_redirect_tgt <= w_tgt;
                            r_state        <= S_DISCARD;
                        end else begin
                            r_pc <= w_tgt;
                        end
                    end else if (!IMEM_BUSYWAIT) begin
                        if (STALL) begin
                            r_hold_instr <= IMEM_READDATA;
                            r_hold_pc    <= r_pc;
                            r_state      <= S_HELD;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                // The in-flight access must finish; the newest target wins.
                S_DISCARD: begin
                    if (!IMEM_BUSYWAIT) begin
                        r_pc    <= PC_SEL ? w_tgt : r_redirect_tgt;
                        r_state <= S_REQ;
                    end else if (PC_SEL) begin
                        r_redirect_tgt <= w_tgt;
                    end
                end
                S_HELD: begin
                    if (PC_SEL) begin
                        r_pc    <= w_tgt;
                        r_state <= S_REQ;
                    end else if (!STALL) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    always_comb begin
        IMEM_READ         = 1'b0;
        BUSYWAIT          = 1'b1;
        FETCH_INSTRUCTION = r_hold_instr;
        FETCH_PC          = r_hold_pc;
        unique case (r_state)
            S_REQ: begin
                IMEM_READ         = 1'b1;
                FETCH_INSTRUCTION = IMEM_READDATA;
                FETCH_PC          = r_pc;
                BUSYWAIT          = IMEM_BUSYWAIT | STALL | PC_SEL;
            end
            S_DISCARD: begin
                IMEM_READ = 1'b1;
            end
            S_HELD: begin
                BUSYWAIT = STALL | PC_SEL;
            end
            default: begin
                IMEM_READ = 1'b0;
            end
        endcase
    end

    assign IMEM_ADDRESS = r_pc;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage front end: owns the program counter, drives the instruction-memory/I-cache read port and produces the instruction/PC pair sampled by the IF/ID pipeline register.
- Handles branch redirect (PC_SEL from EX), hazard stalls from the hazard unit and instruction-memory busywait.
- Non-abortable memory accesses are completed and discarded on redirect.
- A fetched word is buffered during stalls so it is not re-fetched.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect (optional feature only).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- PC_SEL  input  1  branch/jump taken in EX; redirect request, wins over everything.
- BRANCH_TARGET  input  32  redirect address, valid when PC_SEL=1.
- STALL  input  1  hazard-unit hold request (load-use etc.).
- IMEM_READ  output  1  instruction memory read request.
- IMEM_ADDRESS  output  32  instruction memory word address (byte address, [1:0]=0).
- IMEM_READDATA  input  32  instruction word, valid when IMEM_BUSYWAIT=0 with IMEM_READ=1.
- IMEM_BUSYWAIT  input  1  memory busy; access completes at the posedge where IMEM_READ=1 and IMEM_BUSYWAIT=0.
- FETCH_INSTRUCTION  output  32  instruction to IF/ID register.
- FETCH_PC  output  32  PC of FETCH_INSTRUCTION.
- BUSYWAIT  output  1  1 = IF/ID must not capture this cycle.
- MISALIGN_FAULT  output  1  sticky fault flag (optional feature; tied 0 otherwise).

Behaviour:
- States: S_BOOT, S_REQ, S_DISCARD, S_HELD. Registers: pc, redirect_tgt, hold_instr, hold_pc, state.
- Reset (RESET=0, async): state=S_BOOT, pc=RESET_VECTOR, redirect_tgt=0, hold_instr=32'h0000_0013 (NOP), hold_pc=0. Outputs during reset: IMEM_READ=0, IMEM_ADDRESS=RESET_VECTOR, BUSYWAIT=1, FETCH_INSTRUCTION=NOP, FETCH_PC=0, MISALIGN_FAULT=0. Reset mid-access abandons the access; no data is captured.
- S_BOOT: one cycle, IMEM_READ=0, BUSYWAIT=1, then -> S_REQ. PC_SEL is ignored.
- S_REQ: IMEM_READ=1, IMEM_ADDRESS=pc, FETCH_INSTRUCTION=IMEM_READDATA, FETCH_PC=pc. BUSYWAIT=IMEM_BUSYWAIT|STALL|PC_SEL.
  - PC_SEL=1 and IMEM_BUSYWAIT=0: pc<=BRANCH_TARGET, stay S_REQ. The word is discarded.
  - PC_SEL=1 and IMEM_BUSYWAIT=1: redirect_tgt<=BRANCH_TARGET, -> S_DISCARD.
  - PC_SEL=0, IMEM_BUSYWAIT=0, STALL=0: word consumed, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
  - PC_SEL=0, IMEM_BUSYWAIT=0, STALL=1: hold_instr<=IMEM_READDATA, hold_pc<=pc, -> S_HELD. pc is unchanged.
  - IMEM_BUSYWAIT=1, PC_SEL=0: remain; STALL has no effect.
- S_DISCARD: IMEM_READ=1, IMEM_ADDRESS held at old pc, BUSYWAIT=1.
  - On IMEM_BUSYWAIT=0: pc<=redirect_tgt, -> S_REQ. Data is dropped.
  - A new PC_SEL while in S_DISCARD overwrites redirect_tgt (latest wins).
- S_HELD: IMEM_READ=0, FETCH_INSTRUCTION=hold_instr, FETCH_PC=hold_pc, BUSYWAIT=STALL|PC_SEL.
  - PC_SEL=1: pc<=BRANCH_TARGET, -> S_REQ. The buffer is dropped.
  - STALL=0 and PC_SEL=0: IF/ID captures the buffer; pc<=pc+4, -> S_REQ.
- Latency: zero-wait memory gives 1 instruction/cycle after the S_BOOT cycle. First consumable word is at the 2nd posedge after reset release.
- IMEM_ADDRESS is stable for the whole of every access (S_REQ busy, S_DISCARD).

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined: a redirect with BRANCH_TARGET[1:0]!=0 loads TRAP_VECTOR instead, in every redirect path including S_DISCARD. MISALIGN_FAULT is set to 1 and stays 1 until reset.
- Undefined: targets are used as-is with bits [1:0] forced to 0. MISALIGN_FAULT is constant 0.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> IMEM_ADDRESS sequence 0,4,8,C; FETCH_PC/FETCH_INSTRUCTION match; BUSYWAIT=0 from 2nd cycle.
- IMEM_BUSYWAIT=1 for 3 cycles at pc=8 -> IMEM_ADDRESS held at 8, BUSYWAIT=1 for 3 cycles, then pc=C.
- PC_SEL=1, BRANCH_TARGET=0x40 while access to 0x10 busy for 2 more cycles -> 0x10 data never presented with BUSYWAIT=0; next address 0x40.
- STALL=1 for 4 cycles on completion at pc=0x20 -> IMEM_READ=0, FETCH_PC=0x20 held; one capture after release; next address 0x24.
- PC_SEL in S_HELD with target 0x80 -> buffer dropped, IMEM_ADDRESS=0x80 next cycle.
- With PC_MISALIGN_CHECK_EN, BRANCH_TARGET=0x42 -> pc=TRAP_VECTOR, MISALIGN_FAULT=1 until RESET=0.
